// File: rtl/param_bus_if.sv
// param_bus_if
//   Bundles the control word, memory handshake and observation outputs of the
//   single-bus datapath.
//   master : control unit / memory side (drives control word, inport, memory response)
//   slave  : datapath side (drives bus, ir, outport, memory request, busy, mem_err)
//   Parameters W, NREGS, AW must match the datapath instance.
interface param_bus_if #(
  parameter int W     = 32,
  parameter int NREGS = 16,
  parameter int AW    = 9
) ();
  localparam int SELW = $clog2(NREGS + 8);

  logic [SELW-1:0]  bus_src;
  logic             ba_out;
  logic [NREGS-1:0] reg_in;
  logic             hi_in;
  logic             lo_in;
  logic             y_in;
  logic             z_in;
  logic             ir_in;
  logic             mar_in;
  logic             mdr_in;
  logic             outport_in;
  logic             pc_in;
  logic             inc_pc;
  logic [3:0]       alu_op;
  logic             mem_rd;
  logic             mem_wr;
  logic [W-1:0]     inport;
  logic [W-1:0]     mem_rdata;
  logic             mem_ack;

  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [W-1:0]     mem_wdata;
  logic             busy;
  logic             mem_err;
  logic [W-1:0]     bus;
  logic [W-1:0]     ir;
  logic [W-1:0]     outport;

  modport master (
    output bus_src, ba_out, reg_in, hi_in, lo_in, y_in, z_in, ir_in, mar_in,
           mdr_in, outport_in, pc_in, inc_pc, alu_op, mem_rd, mem_wr, inport,
           mem_rdata, mem_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, busy, mem_err, bus, ir, outport
  );

  modport slave (
    input  bus_src, ba_out, reg_in, hi_in, lo_in, y_in, z_in, ir_in, mar_in,
           mdr_in, outport_in, pc_in, inc_pc, alu_op, mem_rd, mem_wr, inport,
           mem_rdata, mem_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, busy, mem_err, bus, ir, outport
  );
endinterface

// File: rtl/param_bus_datapath.sv
// param_bus_datapath
//   Parametrised single-bus CPU datapath: GPRs, HI/LO, Y, Z (2W), PC, IR, MAR,
//   MDR, INPORT, OUTPORT, a combinational ALU (A=Y, B=bus) and a req/ack
//   memory port with wait states and timeout.
//   Ports:
//     clk    rising-edge clock
//     rst_b  synchronous active-low reset
//     bif    param_bus_if.slave: control word in; bus, ir, outport, memory
//            request, busy and sticky mem_err out
//
//   Memory FSM
//   state   | meaning
//   IDLE    | no transaction; MAR/MDR loads from the bus allowed
//   RD      | read pending, mem_req=1; ack captures mem_rdata into MDR
//   WR      | write pending, mem_req=1, mem_we=1; ack completes
//   RD and WR fall back to IDLE with mem_err set after TIMEOUT cycles without ack.
module param_bus_datapath #(
  parameter int W       = 32,
  parameter int NREGS   = 16,
  parameter int AW      = 9,
  parameter int TIMEOUT = 15
) (
  input logic       clk,
  input logic       rst_b,
  param_bus_if.slave bif
);
  localparam int SELW = $clog2(NREGS + 8);
  localparam int SHW  = $clog2(W);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} mem_state_t;

  logic [W-1:0]   gpr [NREGS];
  logic [W-1:0]   hi, lo, y, pc, ir, mdr, inport_q, outport;
  logic [2*W-1:0] z;
  logic [AW-1:0]  mar;

  mem_state_t     state;
  logic           mem_req_q, mem_we_q, busy_q, mem_err_q;
  logic [TW-1:0]  timer;

  logic [W-1:0]    bus_val;
  logic [SELW-1:0] off;
  logic [2*W-1:0]  alu_res;
  logic [2*W-1:0]  a_ext, b_ext;
  logic [SHW-1:0]  sh;

  // Bus source mux; codes past the special-register block read as 0.
  always_comb begin
    bus_val = '0;
    off     = bif.bus_src - SELW'(NREGS);
    for (int i = 0; i < NREGS; i++) begin
      if (bif.bus_src == SELW'(i)) bus_val = gpr[i];
    end
    // BAout forces a zero base address when R0 is the selected source.
    if (bif.ba_out && bif.bus_src == '0) bus_val = '0;
    if (bif.bus_src >= SELW'(NREGS) && off < SELW'(8)) begin
      case (off[2:0])
        3'd0:    bus_val = hi;
        3'd1:    bus_val = lo;
        3'd2:    bus_val = z[2*W-1:W];
        3'd3:    bus_val = z[W-1:0];
        3'd4:    bus_val = pc;
        3'd5:    bus_val = mdr;
        3'd6:    bus_val = inport_q;
        default: bus_val = y;
      endcase
    end
  end

  // ALU: sign-extend both operands to 2W so the multiply yields the full signed product.
  always_comb begin
    alu_res = '0;
    sh      = bus_val[SHW-1:0];
    a_ext   = {{W{y[W-1]}}, y};
    b_ext   = {{W{bus_val[W-1]}}, bus_val};
    case (bif.alu_op)
      4'd0:    alu_res[W-1:0] = y + bus_val;
      4'd1:    alu_res[W-1:0] = y - bus_val;
      4'd2:    alu_res[W-1:0] = y & bus_val;
      4'd3:    alu_res[W-1:0] = y | bus_val;
      4'd4:    alu_res[W-1:0] = y >> sh;
      4'd5:    alu_res[W-1:0] = y << sh;
      4'd6:    alu_res        = a_ext * b_ext;
      4'd7:    alu_res[W-1:0] = ~bus_val;
      4'd8:    alu_res[W-1:0] = -bus_val;
      4'd9:    alu_res[W-1:0] = bus_val + W'(1);
      default: alu_res        = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
      hi       <= '0;
      lo       <= '0;
      y        <= '0;
      z        <= '0;
      pc       <= '0;
      ir       <= '0;
      mar      <= '0;
      inport_q <= '0;
      outport  <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (bif.reg_in[i]) gpr[i] <= bus_val;
      end
      if (bif.hi_in)              hi      <= bus_val;
      if (bif.lo_in)              lo      <= bus_val;
      if (bif.y_in)               y       <= bus_val;
      if (bif.z_in)               z       <= alu_res;
      if (bif.ir_in)              ir      <= bus_val;
      if (bif.outport_in)         outport <= bus_val;
      if (bif.mar_in && !busy_q)  mar     <= bus_val[AW-1:0];
      if (bif.pc_in)              pc      <= bus_val;
      else if (bif.inc_pc)        pc      <= pc + W'(1);
      inport_q <= bif.inport;
    end
  end

  // Memory FSM; MDR lives here because ack capture outranks a bus load.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= ST_IDLE;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      busy_q    <= 1'b0;
      mem_err_q <= 1'b0;
      timer     <= '0;
      mdr       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bif.mdr_in) mdr <= bus_val;
          if (bif.mem_rd || bif.mem_wr) begin
            state     <= bif.mem_rd ? ST_RD : ST_WR;
            mem_req_q <= 1'b1;
            mem_we_q  <= !bif.mem_rd;
            busy_q    <= 1'b1;
            timer     <= TW'(TIMEOUT - 1);
          end
        end
        default: begin
          if (state == ST_RD && bif.mem_ack) mdr <= bif.mem_rdata;
          if (bif.mem_ack || timer == '0) begin
            state     <= ST_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            if (!bif.mem_ack) mem_err_q <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        end
      endcase
    end
  end

  assign bif.bus       = bus_val;
  assign bif.ir        = ir;
  assign bif.outport   = outport;
  assign bif.mem_req   = mem_req_q;
  assign bif.mem_we    = mem_we_q;
  assign bif.mem_addr  = mar;
  assign bif.mem_wdata = mdr;
  assign bif.busy      = busy_q;
  assign bif.mem_err   = mem_err_q;
endmodule
